// File: rtl/regfile_2r1w.sv
// Two-read, one-write register file with per-register written-since-reset flags.
// Optional hardwired-zero register 0 and optional same-cycle write-to-read forwarding.
module regfile_2r1w #(
  parameter int unsigned N       = 16,
  parameter int unsigned K       = 3,
  parameter int unsigned ZERO_R0 = 0,
  parameter int unsigned BYPASS  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  write,
  input  logic [K-1:0]          writenum,
  input  logic [N-1:0]          data_in,
  input  logic [K-1:0]          readnum_a,
  input  logic [K-1:0]          readnum_b,
  output logic [N-1:0]          data_out_a,
  output logic [N-1:0]          data_out_b,
  output logic                  valid_a,
  output logic                  valid_b,
  output logic [(1 << K)-1:0]   valid_mask
);

  localparam int unsigned D         = 1 << K;
  localparam bit          ZERO_EN   = (ZERO_R0 != 0);
  localparam bit          BYPASS_EN = (BYPASS != 0);
  localparam logic [D-1:0] R0_MASK  = ZERO_EN ? D'(1) : '0;

  logic [N-1:0] mem [D];
  logic [D-1:0] valid_q;
  logic         wr_en_c;

  logic [K-1:0] rd_idx   [2];
  logic [N-1:0] rd_data  [2];
  logic         rd_valid [2];

  // Writes to a hardwired-zero register 0 are dropped entirely.
  assign wr_en_c = write && !(ZERO_EN && (writenum == '0));

  // Storage and written-since-reset flags; reset wins over a coincident write.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < D; i++) begin
        mem[i] <= '0;
      end
      valid_q <= '0;
    end else if (wr_en_c) begin
      mem[writenum]     <= data_in;
      valid_q[writenum] <= 1'b1;
    end
  end

  assign valid_mask = valid_q | R0_MASK;

  assign rd_idx[0] = readnum_a;
  assign rd_idx[1] = readnum_b;

  // Read ports: never-written registers read as zero; optional forwarding of the
  // write in flight, which is suppressed when reset will discard that write.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_valid[p] = valid_mask[rd_idx[p]];
      rd_data[p]  = valid_q[rd_idx[p]] ? mem[rd_idx[p]] : '0;
      if (BYPASS_EN && wr_en_c && !reset && (writenum == rd_idx[p])) begin
        rd_data[p]  = data_in;
        rd_valid[p] = 1'b1;
      end
    end
  end

  assign data_out_a = rd_data[0];
  assign data_out_b = rd_data[1];
  assign valid_a    = rd_valid[0];
  assign valid_b    = rd_valid[1];

endmodule

// File: doc/regfile_2r1w.md
REGFILE_2R1W -- requirements
Module: regfile_2r1w

Interface
REQ-001 Parameter N, default 16, data width in bits.
REQ-002 Parameter K, default 3, register address width; depth D = 2^K.
REQ-003 Parameter ZERO_R0, default 0; when 1, register 0 is hardwired to zero.
REQ-004 Parameter BYPASS, default 0; when 1, same-cycle write data forwards to read ports.
REQ-005 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-006 Port reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-007 Port write  input  1  write enable.
REQ-008 Port writenum  input  K  destination register index.
REQ-009 Port data_in  input  N  write data.
REQ-010 Port readnum_a  input  K  read port A index.
REQ-011 Port readnum_b  input  K  read port B index.
REQ-012 Port data_out_a  output  N  read port A data.
REQ-013 Port data_out_b  output  N  read port B data.
REQ-014 Port valid_a  output  1  register at readnum_a has been written since reset.
REQ-015 Port valid_b  output  1  register at readnum_b has been written since reset.
REQ-016 Port valid_mask  output  D  per-register written-since-reset flags, bit i = register i.

Function
REQ-017 Storage SHALL be D registers of N bits plus D valid bits, all updated only on rising edge of clk.
REQ-018 On rising edge with reset=0 and write=1, register[writenum] SHALL load data_in and valid[writenum] SHALL set to 1; write latency one cycle.
REQ-019 With write=0, no register or valid bit SHALL change.
REQ-020 Read ports SHALL be combinational from stored state: data_out_x = register[readnum_x], valid_x = valid[readnum_x], zero-cycle latency.
REQ-021 Both read ports SHALL be independent; readnum_a = readnum_b SHALL return identical data on both.
REQ-022 Reading a register with valid=0 SHALL return all-zeros data, never X.
REQ-023 BYPASS=1: when write=1 and readnum_x = writenum, data_out_x SHALL equal data_in and valid_x SHALL be 1 in the same cycle (unless REQ-025 applies).
REQ-024 BYPASS=0: same-cycle read of the register being written SHALL return the old value; new value visible the cycle after the edge.
REQ-025 ZERO_R0=1: writes to index 0 SHALL be ignored; reads of index 0 SHALL return 0 with valid 1; valid_mask[0] SHALL read 1; no bypass for index 0.
REQ-026 No width extension or truncation: data_in stored exactly N bits; indices use all K bits, no out-of-range case.

Reset
REQ-027 On rising edge with reset=1, all registers SHALL clear to 0 and all valid bits to 0 (bit 0 reads 1 when ZERO_R0=1).
REQ-028 reset SHALL take priority over write in the same cycle; the write is discarded.
REQ-029 After reset, data_out_a, data_out_b = 0, valid_a, valid_b = 0, valid_mask = 0 (except REQ-025).
REQ-030 Reset asserted mid-sequence SHALL discard all prior contents; first write after deassertion behaves per REQ-018.

Verification (N=16, K=3 unless stated)
REQ-031 Reset, then write reg n <- 2n+2 for n=0..7 one per cycle, read A descending 7..0, B ascending 0..7 -> A/B return 16,14,..,2 and 2,4,..,16 respectively, valid 1 throughout.
REQ-032 After reset read all indices with no writes -> data 0x0000, valid 0, valid_mask 8'h00; write reg 5 <- 0xBEEF -> next cycle valid_mask 8'h20, read 5 = 0xBEEF.
REQ-033 BYPASS=0 vs 1: reg 3 = 0x1111, write 0x2222 to reg 3 while readnum_a=3 -> same cycle data_out_a 0x1111 (BYPASS=0) / 0x2222 (BYPASS=1); after edge both 0x2222.
REQ-034 reset=1 and write=1 to reg 4 <- 0xFFFF same edge -> reg 4 reads 0x0000, valid_b 0 at readnum_b=4.
REQ-035 ZERO_R0=1: write reg 0 <- 0xABCD -> read 0 returns 0x0000, valid 1, valid_mask[0]=1 before and after reset.
REQ-036 N=32, K=4: write reg 15 <- 0xDEADBEEF, reg 0 <- 0x00000001 -> reads return exact values, valid_mask 16'h8001; reset mid-stream -> all zero next cycle.
